// File: rtl/offset_aabb_if.sv
// offset_aabb_if: bundles the box-translation datapath signals.
//   in_valid  : input sample valid
//   offset    : Fixed3 offset, x in the top W bits, z in the bottom W bits
//   aabb      : {Min(x,y,z), Max(x,y,z)}, MSB-first
//   out_valid : out_aabb/overflow valid this cycle
//   out_aabb  : translated box, same packing as aabb
//   overflow  : per-lane overflow, [5:3]=Min x,y,z, [2:0]=Max x,y,z
// master drives the inputs; slave is the translating stage.
interface offset_aabb_if #(
  parameter int W = 32
);
  logic           in_valid;
  logic [3*W-1:0] offset;
  logic [6*W-1:0] aabb;
  logic           out_valid;
  logic [6*W-1:0] out_aabb;
  logic [5:0]     overflow;

  modport master (
    output in_valid, offset, aabb,
    input  out_valid, out_aabb, overflow
  );

  modport slave (
    input  in_valid, offset, aabb,
    output out_valid, out_aabb, overflow
  );
endinterface

// File: rtl/offset_aabb.sv
// offset_aabb: translates an axis-aligned bounding box by a 3-D fixed-point
// offset (Min + offset, Max + offset) in a single registered stage.
//   clk    : clock, all state on posedge
//   resetn : synchronous active-low reset; clears valid, box and flags
//   bus    : offset_aabb_if slave (in_valid/offset/aabb in,
//            out_valid/out_aabb/overflow out)
// Parameters:
//   W        : scalar width (signed two's complement)
//   SATURATE : 1 clamps overflowing lanes to signed min/max, 0 wraps
module offset_aabb #(
  parameter int W        = 32,
  parameter bit SATURATE = 1'b1
) (
  input  logic         clk,
  input  logic         resetn,
  offset_aabb_if.slave bus
);

  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  // Returns {overflow, result}. Overflow means both operands share a sign
  // that the W-bit sum does not.
  function automatic logic [W:0] add_sat(input logic signed [W-1:0] a,
                                         input logic signed [W-1:0] b);
    logic [W:0]   s;
    logic         ovf;
    logic [W-1:0] r;
    s   = {a[W-1], a} + {b[W-1], b};
    ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    if (ovf && SATURATE) r = a[W-1] ? SMIN : SMAX;
    else                 r = s[W-1:0];
    return {ovf, r};
  endfunction

  logic [6*W-1:0] sum_p0;
  logic [5:0]     ovf_p0;

  logic           vld_p1;
  logic [6*W-1:0] aabb_p1;
  logic [5:0]     ovf_p1;

  // Stage 0: six independent lanes. Lane k sits at aabb[k*W +: W]; lanes
  // 0..2 are Max z,y,x and 3..5 are Min z,y,x, so the offset lane is k%3.
  for (genvar k = 0; k < 6; k++) begin : g_lane
    logic [W:0] r;
    assign r = add_sat(bus.aabb[k*W +: W], bus.offset[(k%3)*W +: W]);
    assign sum_p0[k*W +: W] = r[W-1:0];
    assign ovf_p0[k]        = r[W];
  end

  // Stage 1: output register; box and flags hold while no sample arrives.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1  <= 1'b0;
      aabb_p1 <= '0;
      ovf_p1  <= '0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        aabb_p1 <= sum_p0;
        ovf_p1  <= ovf_p0;
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.out_aabb  = aabb_p1;
  assign bus.overflow  = ovf_p1;

endmodule

// File: tb/tb_offset_aabb.sv
// tb_offset_aabb: directed and model-checked bench for offset_aabb, with a
// saturating instance and a wrapping instance fed the same inputs.
module tb_offset_aabb;

  localparam int W = 32;
  localparam longint SMAX_L = 64'sd2147483647;
  localparam longint SMIN_L = -64'sd2147483648;

  logic clk = 1'b0;
  logic resetn;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  offset_aabb_if #(.W(W)) bus ();
  offset_aabb_if #(.W(W)) bus_w ();

  assign bus_w.in_valid = bus.in_valid;
  assign bus_w.offset   = bus.offset;
  assign bus_w.aabb     = bus.aabb;

  offset_aabb #(.W(W), .SATURATE(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  offset_aabb #(.W(W), .SATURATE(1'b0)) dut_w (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_w)
  );

  task automatic chk(input string tag, input logic [191:0] got,
                     input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [95:0] off,
                       input logic [191:0] bx);
    bus.in_valid = v;
    bus.offset   = off;
    bus.aabb     = bx;
  endtask

  function automatic logic [95:0] v3(input logic [31:0] x, input logic [31:0] y,
                                     input logic [31:0] z);
    return {x, y, z};
  endfunction

  function automatic logic [191:0] rnd_box;
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [95:0] rnd_off;
    return {$urandom, $urandom, $urandom};
  endfunction

  // Golden model: exact 64-bit sum per lane, range-tested against W=32 limits.
  function automatic logic [197:0] model(input logic [95:0] off,
                                         input logic [191:0] bx,
                                         input bit sat);
    logic [191:0] r;
    logic [5:0]   o;
    int           a, b;
    longint       s;
    logic [63:0]  su;
    r = '0;
    o = '0;
    for (int k = 0; k < 6; k++) begin
      a  = bx[k*32 +: 32];
      b  = off[(k%3)*32 +: 32];
      s  = longint'(a) + longint'(b);
      su = s;
      if (s > SMAX_L) begin
        o[k] = 1'b1;
        r[k*32 +: 32] = sat ? 32'h7FFFFFFF : su[31:0];
      end else if (s < SMIN_L) begin
        o[k] = 1'b1;
        r[k*32 +: 32] = sat ? 32'h80000000 : su[31:0];
      end else begin
        r[k*32 +: 32] = su[31:0];
      end
    end
    return {o, r};
  endfunction

  logic [95:0]  off_b, off_t;
  logic [191:0] box_b, box_t, exp_box, held_box;
  logic [5:0]   held_ovf;
  logic [197:0] m;
  logic [95:0]  s_off [8];
  logic [191:0] s_box [8];
  logic         v;

  initial begin
    resetn = 1'b0;
    off_b  = v3(32'h00008000, 32'hFFFF0000, 32'h00020000);
    box_b  = {v3(32'h00010000, 32'h00020000, 32'hFFFD0000),
              v3(32'h00040000, 32'h00050000, 32'h00060000)};

    // Reset wins over in_valid
    drive(1'b1, off_b, box_b);
    step;
    step;
    chk("rst_valid", 192'(bus.out_valid), 192'd0);
    chk("rst_aabb",  bus.out_aabb, 192'd0);
    chk("rst_ovf",   192'(bus.overflow), 192'd0);

    resetn = 1'b1;
    drive(1'b0, off_b, box_b);
    step;
    chk("post_rst_idle", 192'(bus.out_valid), 192'd0);

    // Basic Q16.16
    drive(1'b1, off_b, box_b);
    step;
    chk("basic_valid", 192'(bus.out_valid), 192'd1);
    chk("basic_aabb", bus.out_aabb,
        {v3(32'h00018000, 32'h00010000, 32'hFFFF0000),
         v3(32'h00048000, 32'h00040000, 32'h00080000)});
    chk("basic_ovf", 192'(bus.overflow), 192'd0);

    // Idle cycle holds data
    drive(1'b0, 96'd0, 192'd0);
    step;
    chk("hold_valid", 192'(bus.out_valid), 192'd0);
    chk("hold_aabb", bus.out_aabb,
        {v3(32'h00018000, 32'h00010000, 32'hFFFF0000),
         v3(32'h00048000, 32'h00040000, 32'h00080000)});

    // Positive overflow on Max.x
    drive(1'b1, v3(32'h00020000, 32'd0, 32'd0),
          {v3(32'd0, 32'd0, 32'd0), v3(32'h7FFF0000, 32'd0, 32'd0)});
    step;
    chk("possat_aabb", bus.out_aabb,
        {v3(32'h00020000, 32'd0, 32'd0), v3(32'h7FFFFFFF, 32'd0, 32'd0)});
    chk("possat_ovf", 192'(bus.overflow), 192'(6'b000100));
    chk("poswrap_aabb", bus_w.out_aabb,
        {v3(32'h00020000, 32'd0, 32'd0), v3(32'h80010000, 32'd0, 32'd0)});
    chk("poswrap_ovf", 192'(bus_w.overflow), 192'(6'b000100));

    // Negative overflow on Min.z
    drive(1'b1, v3(32'd0, 32'd0, 32'hFFFFFFFF),
          {v3(32'd0, 32'd0, 32'h80000000), v3(32'd0, 32'd0, 32'd0)});
    step;
    chk("negsat_aabb", bus.out_aabb,
        {v3(32'd0, 32'd0, 32'h80000000), v3(32'd0, 32'd0, 32'hFFFFFFFF)});
    chk("negsat_ovf", 192'(bus.overflow), 192'(6'b001000));
    chk("negwrap_aabb", bus_w.out_aabb,
        {v3(32'd0, 32'd0, 32'h7FFFFFFF), v3(32'd0, 32'd0, 32'hFFFFFFFF)});

    // Min > Max passes through unordered
    drive(1'b1, v3(32'h00010000, 32'h00010000, 32'h00010000),
          {v3(32'h00050000, 32'h00050000, 32'h00050000),
           v3(32'h00010000, 32'h00010000, 32'h00010000)});
    step;
    chk("noreorder_aabb", bus.out_aabb,
        {v3(32'h00060000, 32'h00060000, 32'h00060000),
         v3(32'h00020000, 32'h00020000, 32'h00020000)});

    // Zero offset is identity
    for (int i = 0; i < 3; i++) begin
      box_t = rnd_box();
      drive(1'b1, 96'd0, box_t);
      step;
      chk("zero_off_aabb", bus.out_aabb, box_t);
      chk("zero_off_ovf", 192'(bus.overflow), 192'd0);
    end

    // Streaming: 8 boxes, gap after box 4
    for (int i = 0; i < 8; i++) begin
      s_off[i] = rnd_off();
      s_box[i] = rnd_box();
    end
    for (int slot = 0; slot < 9; slot++) begin
      if (slot == 4) begin
        drive(1'b0, rnd_off(), rnd_box());
        step;
        m = model(s_off[3], s_box[3], 1'b1);
        chk("stream_gap_valid", 192'(bus.out_valid), 192'd0);
        chk("stream_gap_hold", bus.out_aabb, m[191:0]);
        chk("stream_gap_ovf", 192'(bus.overflow), 192'(m[197:192]));
      end else begin
        drive(1'b1, s_off[slot < 4 ? slot : slot-1], s_box[slot < 4 ? slot : slot-1]);
        step;
        m = model(bus.offset, bus.aabb, 1'b1);
        chk("stream_valid", 192'(bus.out_valid), 192'd1);
        chk("stream_aabb", bus.out_aabb, m[191:0]);
        chk("stream_ovf", 192'(bus.overflow), 192'(m[197:192]));
      end
    end

    // Reset mid-stream
    drive(1'b1, rnd_off(), rnd_box());
    resetn = 1'b0;
    step;
    chk("midrst_valid", 192'(bus.out_valid), 192'd0);
    chk("midrst_aabb", bus.out_aabb, 192'd0);
    chk("midrst_ovf", 192'(bus.overflow), 192'd0);
    resetn = 1'b1;
    held_box = '0;
    held_ovf = '0;

    // Random traffic with sporadic idle cycles, both instances
    for (int i = 0; i < 40; i++) begin
      v     = ($urandom_range(0, 3) != 0);
      off_t = rnd_off();
      box_t = rnd_box();
      drive(v, off_t, box_t);
      step;
      if (v) begin
        m        = model(off_t, box_t, 1'b1);
        held_box = m[191:0];
        held_ovf = m[197:192];
        m        = model(off_t, box_t, 1'b0);
        exp_box  = m[191:0];
        chk("rand_wrap_aabb", bus_w.out_aabb, exp_box);
        chk("rand_wrap_ovf", 192'(bus_w.overflow), 192'(held_ovf));
      end
      chk("rand_valid", 192'(bus.out_valid), 192'(v));
      chk("rand_aabb", bus.out_aabb, held_box);
      chk("rand_ovf", 192'(bus.overflow), 192'(held_ovf));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
